data_mem_resp: RTL
==================

# data_mem_resp

Data-memory responder for the pipelined CPU's MEM-stage port. It accepts the CPU's single-cycle memory requests (address, write data, store/load size strobes) and returns read data in the same cycle, combinationally. The CPU registers that data into MEM/WB at the next edge. Stores are placed on the correct byte lanes, buffered in a small store buffer, and drained to the storage array in the background. Loads see all older stores through byte-lane forwarding.

## Interface
Parameters:
- ADDR_W, 10: word-address bits; array holds 2^ADDR_W 32-bit words (default 4 KB).
- SB_DEPTH, 4: store-buffer entries; power of two, >= 2.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- mem_addr  in  32  byte address
- mem_write_data  in  32  store data, right-justified for sb/sh
- mem_wr  in  1  store this cycle
- mem_sb  in  1  store size byte (with mem_wr)
- mem_sh  in  1  store size halfword (with mem_wr)
- mem_lb  in  1  load size byte
- mem_lh  in  1  load size halfword
- mem_read_data  out  32  load data, right-justified, upper bits zero
- stbuf_count  out  $clog2(SB_DEPTH)+1  occupied store-buffer entries
- stbuf_full  out  1  stbuf_count == SB_DEPTH

## Operation
**Addressing**
- Byte order is big-endian: byte offset 0 is bits [31:24] and offset 3 is bits [7:0].
- Word index is mem_addr[ADDR_W+1:2]. Higher address bits are ignored, so addresses wrap modulo array size.
- Misaligned access is forced to alignment: halfword ignores mem_addr[0], word ignores mem_addr[1:0].

**Store lane formation**
- sb: mem_write_data[7:0] goes to the addressed byte; one-hot byte enable.
- sh: mem_write_data[15:0] goes to the addressed halfword; two-bit enable.
- Neither strobe set: full word, enable 4'b1111.
- sb and sh together: sb wins.

**Store buffer**
- FIFO of {word index, 4-bit byte enable, 32-bit lane data}.
- A store with mem_wr=1 enqueues at the rising edge.
- Drain: the oldest entry is written to the array, enabled bytes only, at an edge where the buffer is non-empty and either mem_wr=0 or the buffer is full.
- Full plus store: drain and enqueue happen at the same edge. No store is ever dropped.
- Drain and enqueue at the same edge leave the count unchanged.

**Loads**
- Every cycle, mem_read_data is computed from the array word at the word index.
- That word is overlaid with enabled bytes from every matching buffer entry, applied oldest to youngest, so the youngest store wins per byte.
- An entry draining at the coming edge still forwards during the current cycle.
- lb returns {24'b0, byte}. lh returns {16'b0, halfword}. Otherwise the full word is returned.
- lb and lh together: lb wins.
- Sign extension is not done here; it belongs to write-back.

**Reset**
- Clears the FIFO pointers and count, which discards un-drained stores.
- Does not clear array contents; they are undefined until written.

## Timing
- Read latency is 0 cycles (combinational from mem_addr, strobes, array and buffer).
- A store issued in cycle N is visible to a load in cycle N+1 via forwarding.
- That store reaches the array at the first later drain edge.
- Worst-case drain lag: SB_DEPTH edges after the last of a back-to-back store burst.
- Reset values: stbuf_count=0, stbuf_full=0. mem_read_data follows the array.
- Reset takes effect immediately, without waiting for an edge, including mid-burst.
- The first edge after deassertion behaves as from empty.

## Configuration
- DMEM_STBUF_EN defined:
  - Store buffer, drain policy and forwarding as above.
- DMEM_STBUF_EN undefined:
  - No buffer. Stores write enabled bytes directly into the array at the rising edge of the store cycle.
  - Loads read the array only.
  - stbuf_count and stbuf_full are tied to 0.
  - Architectural results are identical in both configurations.

## Test plan
1. Reset, then sw 0xDEADBEEF @0x10, then lw @0x10 next cycle -> 0xDEADBEEF with stbuf_count=1. After one idle edge -> stbuf_count=0 and still 0xDEADBEEF.
2. Word @0x10 = 0x11223344, then sb data 0xAB @0x13 -> lw @0x10 = 0x112233AB, lb @0x13 = 0x000000AB, lb @0x10 = 0x00000011.
3. sh 0xCAFE @0x12 on 0x11223344 -> lw = 0x1122CAFE, lh @0x12 = 0x0000CAFE. lh @0x11 (misaligned) reads @0x10 -> 0x00001122.
4. Six back-to-back sw to words 0x0..0x14 with SB_DEPTH=4 -> count 1,2,3,4,4,4 and stbuf_full=1 from the fourth edge. All six words read back correctly after draining.
5. sw 0x00000001 @0x20 then sb 0xFF @0x20 (both buffered) -> lw @0x20 = 0xFF000001. Same value after drain.
6. Three buffered stores, then reset pulsed between edges -> stbuf_count=0 asynchronously; those stores never reach the array. Also sw @0x1000 with ADDR_W=10 -> lw @0x0 returns the value (wrap).

Source files
------------

// File: rtl/data_mem_resp.sv
// MEM-stage data memory: combinational big-endian loads, byte-lane stores.
// Define DMEM_STBUF_EN to add the forwarding store buffer; otherwise stores write the array directly.
module data_mem_resp #(
  parameter int ADDR_W   = 10,
  parameter int SB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 mem_addr,
  input  logic [31:0]                 mem_write_data,
  input  logic                        mem_wr,
  input  logic                        mem_sb,
  input  logic                        mem_sh,
  input  logic                        mem_lb,
  input  logic                        mem_lh,
  output logic [31:0]                 mem_read_data,
  output logic [$clog2(SB_DEPTH):0]   stbuf_count,
  output logic                        stbuf_full
);

  localparam int CNT_W = $clog2(SB_DEPTH) + 1;

  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        byte_off;
  logic [3:0]        st_be;
  logic [31:0]       st_data;
  logic              unused_addr_hi;

  assign word_idx       = mem_addr[ADDR_W+1:2];
  assign byte_off       = mem_addr[1:0];
  assign unused_addr_hi = ^mem_addr[31:ADDR_W+2];

  // Byte-enable bit 3 is offset 0 (bits 31:24); data is replicated so every lane lines up.
  always_comb begin
    st_be   = 4'b1111;
    st_data = mem_write_data;
    if (mem_sb) begin
      st_be   = 4'b1000 >> byte_off;
      st_data = {4{mem_write_data[7:0]}};
    end else if (mem_sh) begin
      st_be   = byte_off[1] ? 4'b0011 : 4'b1100;
      st_data = {2{mem_write_data[15:0]}};
    end
  end

  logic [31:0]       mem_q [2**ADDR_W];
  logic              arr_we;
  logic [ADDR_W-1:0] arr_idx;
  logic [3:0]        arr_be;
  logic [31:0]       arr_wdata;
  logic [31:0]       arr_rd;
  logic [31:0]       fwd_word;

  assign arr_rd = mem_q[word_idx];

  always_ff @(posedge clk) begin
    if (arr_we) begin
      for (int b = 0; b < 4; b++) begin
        if (arr_be[b]) mem_q[arr_idx][8*b +: 8] <= arr_wdata[8*b +: 8];
      end
    end
  end

`ifdef DMEM_STBUF_EN
  localparam int PTR_W = $clog2(SB_DEPTH);

  logic [ADDR_W-1:0] sb_idx_q  [SB_DEPTH];
  logic [3:0]        sb_be_q   [SB_DEPTH];
  logic [31:0]       sb_data_q [SB_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full;
  logic              drain;
  logic [PTR_W-1:0]  slot;

  assign full  = (count_q == CNT_W'(SB_DEPTH));
  // A full buffer always drains, so a store arriving then never stalls or drops.
  assign drain = (count_q != '0) && (!mem_wr || full);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (mem_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (drain)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({mem_wr, drain})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      sb_idx_q[wr_ptr_q]  <= word_idx;
      sb_be_q[wr_ptr_q]   <= st_be;
      sb_data_q[wr_ptr_q] <= st_data;
    end
  end

  assign arr_we    = drain;
  assign arr_idx   = sb_idx_q[rd_ptr_q];
  assign arr_be    = sb_be_q[rd_ptr_q];
  assign arr_wdata = sb_data_q[rd_ptr_q];

  // Walk oldest to youngest so the youngest matching store owns each byte.
  always_comb begin
    fwd_word = arr_rd;
    slot     = rd_ptr_q;
    for (int i = 0; i < SB_DEPTH; i++) begin
      slot = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (sb_idx_q[slot] == word_idx)) begin
        for (int b = 0; b < 4; b++) begin
          if (sb_be_q[slot][b]) fwd_word[8*b +: 8] = sb_data_q[slot][8*b +: 8];
        end
      end
    end
  end

  assign stbuf_count = count_q;
  assign stbuf_full  = full;
`else
  // Stores during reset are discarded, matching the buffered build.
  assign arr_we      = mem_wr && !reset;
  assign arr_idx     = word_idx;
  assign arr_be      = st_be;
  assign arr_wdata   = st_data;
  assign fwd_word    = arr_rd;
  assign stbuf_count = '0;
  assign stbuf_full  = 1'b0;
`endif

  always_comb begin
    mem_read_data = fwd_word;
    if (mem_lb) begin
      case (byte_off)
        2'd0:    mem_read_data = {24'b0, fwd_word[31:24]};
        2'd1:    mem_read_data = {24'b0, fwd_word[23:16]};
        2'd2:    mem_read_data = {24'b0, fwd_word[15:8]};
        default: mem_read_data = {24'b0, fwd_word[7:0]};
      endcase
    end else if (mem_lh) begin
      mem_read_data = byte_off[1] ? {16'b0, fwd_word[15:0]} : {16'b0, fwd_word[31:16]};
    end
  end

endmodule
